wide_addsub_serial: RTL
=======================

# wide_addsub_serial

Parametrised multi-cycle wide adder/subtractor for the big-integer datapath. It succeeds the fixed 513-bit single-cycle adder. It computes `in_a + in_b` or `in_a - in_b` over `WIDTH+1` bits, processing `CHUNK` bits per cycle with a registered carry, which bounds the critical path to one `CHUNK`-bit add. The block keeps the existing `start`/`done` handshake, adds a `busy` status, and makes latency a function of the parameters.

## Interface
- `WIDTH`, default 513: operand width in bits; result is `WIDTH+1` bits.
- `CHUNK`, default 128: bits added per cycle, `1 <= CHUNK <= WIDTH+1`.
- Derived: `NCHUNK = ceil((WIDTH+1)/CHUNK)`; 5 at the defaults.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only when accepted (see Operation).
- `subtract`  in  1  0 = add, 1 = subtract; sampled with `start`.
- `in_a`  in  `WIDTH`  operand A, unsigned; sampled with `start`.
- `in_b`  in  `WIDTH`  operand B, unsigned; sampled with `start`.
- `result`  out  `WIDTH+1`  last completed result; holds until the next completion.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- States:
  - IDLE: `busy` = 0.
  - RUN: a chunk counter `idx` runs from 0 to `NCHUNK-1`.
  - DONE: `done` = 1.
- Reset, asynchronous: state goes to IDLE, `idx` = 0, carry = 0, and the internal operand registers are cleared. Outputs reset to `result` = 0, `done` = 0, `busy` = 0.
- IDLE, `start` = 1: accept the request and go to RUN with `idx` = 0.
  - Load A = zero-extend(`in_a`) and B = zero-extend(`in_b`), both to `WIDTH+1` bits.
  - When `subtract` = 1, invert B across all `WIDTH+1` bits and set carry = 1; otherwise carry = 0.
- RUN, each cycle:
  - Add chunk `idx` of A and B plus carry, producing a `CHUNK`-bit sum and a new carry.
  - Write the sum into chunk `idx` of the working register.
  - Bits above `WIDTH` in the last partial chunk are padding and are discarded.
- RUN, at `idx` = `NCHUNK-1`: copy the low `WIDTH+1` bits of the completed working register into `result`, then go to DONE.
- DONE lasts one cycle, then returns to IDLE. Back-to-back behaviour is set under Configuration.
- Arithmetic, exact and with no overflow possible:
  - Add: `result` = `in_a + in_b`; bit `WIDTH` is the carry out.
  - Subtract: `result` = `in_a - in_b` as a `WIDTH+1`-bit two's complement value; bit `WIDTH` is the sign.
- `start` is ignored in RUN. Operand and `subtract` changes after acceptance have no effect.
- `result` never shows partial sums. It changes only on the edge that enters DONE, or on reset.
- `CHUNK = WIDTH+1` gives `NCHUNK` = 1, i.e. a single RUN cycle.

## Timing
- Request accepted at edge E0, with `start` = 1 in IDLE.
- Edges E1…E`NCHUNK` are the RUN edges. `result` is updated and `done` rises at edge E`NCHUNK`.
- `done` is high for exactly one cycle, between E`NCHUNK` and E`NCHUNK+1`.
- Latency from the acceptance edge to `done` is `NCHUNK` cycles; 5 at the defaults.
- `busy` rises at E0 and falls at E`NCHUNK+1`, unless a back-to-back start is accepted.
- Without back-to-back support, a new acceptance is possible at E`NCHUNK+2` at the earliest. The throughput period is `NCHUNK+2` cycles.
- Reset asserted mid-operation:
  - The operation is aborted immediately.
  - No `done` pulse is produced.
  - `result` = 0.
  - A request accepted after reset is released behaves normally.

## Configuration
- `WIDE_ADDSUB_BACK2BACK_EN` defined:
  - `start` = 1 in DONE is accepted as a new request at the DONE→next edge, loading operands exactly as from IDLE and going straight to RUN.
  - `busy` stays high.
  - The throughput period becomes `NCHUNK+1` cycles.
- Not defined: `start` in DONE is ignored, DONE always returns to IDLE, and a request must be presented in IDLE.

## Test plan
Defaults apply: `WIDTH` = 513, `CHUNK` = 128.
- Reset: drive `resetn` = 0 with random inputs → `result` = 0, `done` = 0, `busy` = 0. Release; with `start` = 0 all three stay 0.
- Add with full carry ripple: A = 2^513−1, B = 1, `subtract` = 0 → `result` = 2^513 (only bit 513 set). `done` pulses exactly 5 cycles after acceptance, for 1 cycle, and `busy` is high for 6 cycles.
- Carry across a chunk boundary: A = 2^128−1, B = 1 → `result` = 2^128. Repeat with A = 2^384−1, B = 1 → `result` = 2^384.
- Subtract with a negative result: A = 5, B = 7, `subtract` = 1 → `result` = 2^514−2 (all ones except bit 0). Then A = 7, B = 5 → `result` = 2.
- Ignored inputs: pulse `start` with new operands during RUN cycle 2 → no effect, and the first result completes unchanged. Assert `resetn` = 0 in RUN cycle 3 → no `done`, `result` = 0. A fresh request afterwards (A = 1, B = 1) completes with `result` = 2.
- Back-to-back: hold `start` = 1 continuously with A = 1, B = 2.
  - Macro defined: `done` pulses every 6 cycles and `busy` never drops.
  - Macro undefined: `done` pulses every 7 cycles and `busy` drops for one cycle between operations.
  - Both cases: `result` = 3.

Source files
------------

// File: rtl/wide_addsub_serial.sv
// wide_addsub_serial: multi-cycle wide adder/subtractor, CHUNK bits per cycle with a
// registered carry. Result is WIDTH+1 bits (carry out or sign in the top bit).
// Optional feature: define WIDE_ADDSUB_BACK2BACK_EN to accept a new request in DONE.
module wide_addsub_serial #(
   parameter int unsigned WIDTH = 513,
   parameter int unsigned CHUNK = 128
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic             subtract,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             done,
   output logic             busy
);

   localparam int unsigned W1     = WIDTH + 1;
   localparam int unsigned NCHUNK = (W1 + CHUNK - 1) / CHUNK;
   localparam int unsigned PW     = NCHUNK * CHUNK;
   localparam int unsigned IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IW-1:0] LastIdx = IW'(NCHUNK - 1);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e                       state_q;
   logic [NCHUNK-1:0][CHUNK-1:0] a_q, b_q, work_q, work_nxt;
   logic [IW-1:0]                idx_q;
   logic                         carry_q;
   logic [CHUNK-1:0]             sum;
   logic                         carry_nxt;
   logic [PW-1:0]                a_load, b_load, work_flat;

   // Chunk adder, working-register merge and operand load values (padding bits stay zero)
   always_comb begin
      {carry_nxt, sum} = {1'b0, a_q[idx_q]} + {1'b0, b_q[idx_q]} + {{CHUNK{1'b0}}, carry_q};
      work_nxt         = work_q;
      work_nxt[idx_q]  = sum;
      work_flat        = work_nxt;
      a_load           = PW'(in_a);
      b_load           = PW'({1'b0, in_b} ^ {W1{subtract}});
   end

   // Control FSM with registered outputs; result only moves on entry to DONE
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         work_q  <= '0;
         result  <= '0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  a_q     <= a_load;
                  b_q     <= b_load;
                  carry_q <= subtract;
                  idx_q   <= '0;
                  busy    <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               work_q  <= work_nxt;
               carry_q <= carry_nxt;
               if (idx_q == LastIdx) begin
                  result  <= work_flat[WIDTH:0];
                  done    <= 1'b1;
                  idx_q   <= '0;
                  state_q <= StDone;
               end else begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            StDone: begin
`ifdef WIDE_ADDSUB_BACK2BACK_EN
               if (start) begin
                  a_q     <= a_load;
                  b_q     <= b_load;
                  carry_q <= subtract;
                  idx_q   <= '0;
                  state_q <= StRun;
               end else begin
                  busy    <= 1'b0;
                  state_q <= StIdle;
               end
`else
               busy    <= 1'b0;
               state_q <= StIdle;
`endif
            end
            default: begin
               busy    <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule
